// File: rtl/parking_exit_gate_if.sv
// Exit-gate bundle: exit request, payment beats, and billing/occupancy results.
// master = lot-side driver, slave = the gate controller.
interface parking_exit_gate_if;
  logic       exit;
  logic [2:0] token;
  logic [2:0] pattern;
  logic [7:0] parking_capacity;
  logic [7:0] time_in;
  logic [7:0] time_out;
  logic       pay_valid;
  logic [7:0] pay_amount;
  logic       busy;
  logic [7:0] park_location;
  logic [7:0] time_total;
  logic [7:0] fee;
  logic       gate_open;
  logic       exit_done;
  logic       exit_error;
  logic [1:0] err_code;
  logic [7:0] new_capacity;
  logic [3:0] parked;
  logic [3:0] empty;

  modport master (
    output exit, token, pattern, parking_capacity, time_in, time_out,
           pay_valid, pay_amount,
    input  busy, park_location, time_total, fee, gate_open, exit_done,
           exit_error, err_code, new_capacity, parked, empty
  );

  modport slave (
    input  exit, token, pattern, parking_capacity, time_in, time_out,
           pay_valid, pay_amount,
    output busy, park_location, time_total, fee, gate_open, exit_done,
           exit_error, err_code, new_capacity, parked, empty
  );
endinterface

// File: rtl/parking_exit_gate.sv
// Exit-side gate controller: token -> slot decode, occupancy check, billing,
// payment collection with timeout, timed gate opening, occupancy update.
// Optional feature macro: EXIT_GRACE_EN (stays of GRACE_TIME or less are free).
module parking_exit_gate #(
  parameter int RATE        = 1,
  parameter int PAY_TIMEOUT = 64,
  parameter int GATE_CYCLES = 4,
  parameter int GRACE_TIME  = 5
) (
  input  logic               clk,
  input  logic               rst,
  parking_exit_gate_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, DECODE, CHECK, BILL, WAIT_PAY, OPEN, ERROR
  } state_t;

  // request snapshot taken when an exit is accepted
  typedef struct packed {
    logic [2:0] slot;
    logic [7:0] cap;
    logic [7:0] t_in;
    logic [7:0] t_out;
  } req_t;

`ifdef EXIT_GRACE_EN
  localparam bit GRACE_ON = 1'b1;
`else
  localparam bit GRACE_ON = 1'b0;
`endif
  localparam logic [31:0] RATE_U  = RATE;
  localparam logic [31:0] GRACE_U = GRACE_TIME;

  state_t      state_q, state_d;
  req_t        req_q;
  logic [7:0]  loc_q, tt_q, fee_q, paid_q, newcap_q;
  logic [1:0]  err_q;
  logic [15:0] cnt_q;

  logic [31:0] prod;
  logic [7:0]  fee_calc;
  logic [8:0]  paid_add;
  logic [7:0]  paid_sum;
  logic        pay_ok, to_hit, gate_last, occupied;
  logic [7:0]  cap_clr;
  logic [3:0]  parked_c;

  assign occupied  = req_q.cap[req_q.slot];
  assign cap_clr   = req_q.cap & ~loc_q;
  assign to_hit    = (cnt_q == 16'(PAY_TIMEOUT - 1));
  assign gate_last = (cnt_q == 16'(GATE_CYCLES - 1));

  // saturating fee from the registered stay length; grace zeroes short stays
  always_comb begin
    prod     = {24'd0, tt_q} * RATE_U;
    fee_calc = (prod > 32'd255) ? 8'd255 : prod[7:0];
    if (GRACE_ON && ({24'd0, tt_q} <= GRACE_U)) fee_calc = 8'd0;
  end

  // saturating accumulate of this cycle's payment beat
  always_comb begin
    paid_add = {1'b0, paid_q} + {1'b0, bus.pay_amount};
    paid_sum = paid_q;
    if (bus.pay_valid) paid_sum = paid_add[8] ? 8'hFF : paid_add[7:0];
    pay_ok   = bus.pay_valid && (paid_sum >= fee_q);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state; payment completion is tested before the timeout so it wins a tie
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.exit) state_d = DECODE;
      DECODE:   state_d = CHECK;
      CHECK:    state_d = occupied ? BILL : ERROR;
      BILL:     state_d = (fee_calc == 8'd0) ? OPEN : WAIT_PAY;
      WAIT_PAY: begin
        if (pay_ok)      state_d = OPEN;
        else if (to_hit) state_d = ERROR;
      end
      OPEN:     if (gate_last) state_d = IDLE;
      ERROR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // datapath: capture, decode, billing, payment and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      loc_q    <= '0;
      tt_q     <= '0;
      fee_q    <= '0;
      paid_q   <= '0;
      newcap_q <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.exit) begin
          req_q <= '{slot:  bus.token ^ bus.pattern,
                     cap:   bus.parking_capacity,
                     t_in:  bus.time_in,
                     t_out: bus.time_out};
          err_q <= 2'b00;
        end
        DECODE: begin
          loc_q <= 8'd1 << req_q.slot;
          tt_q  <= req_q.t_out - req_q.t_in;
        end
        CHECK: if (!occupied) begin
          err_q    <= 2'b01;
          newcap_q <= req_q.cap;
        end
        BILL: begin
          fee_q  <= fee_calc;
          paid_q <= 8'd0;
          cnt_q  <= 16'd0;
          if (fee_calc == 8'd0) newcap_q <= cap_clr;
        end
        WAIT_PAY: begin
          paid_q <= paid_sum;
          if (pay_ok) begin
            newcap_q <= cap_clr;
            cnt_q    <= 16'd0;
          end else if (to_hit) begin
            err_q    <= 2'b10;
            newcap_q <= req_q.cap;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        OPEN:    cnt_q <= cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  // occupancy counts straight off the published bitmap
  always_comb begin
    parked_c = '0;
    for (int i = 0; i < 8; i++) parked_c = parked_c + 4'(newcap_q[i]);
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.gate_open     = (state_q == OPEN);
  assign bus.exit_done     = (state_q == OPEN) && gate_last;
  assign bus.exit_error    = (state_q == ERROR);
  assign bus.park_location = loc_q;
  assign bus.time_total    = tt_q;
  assign bus.fee           = fee_q;
  assign bus.err_code      = err_q;
  assign bus.new_capacity  = newcap_q;
  assign bus.parked        = parked_c;
  assign bus.empty         = 4'd8 - parked_c;

endmodule

// File: tb/tb_parking_exit_gate.sv
// Scoreboard bench for parking_exit_gate: the driver predicts each exit's
// outcome and queues it; a negedge monitor checks every done/error pulse.
module tb_parking_exit_gate;
  localparam int RATE        = 2;
  localparam int PAY_TIMEOUT = 64;
  localparam int GATE_CYCLES = 4;
  localparam int GRACE_TIME  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_exit_gate_if bus();

  parking_exit_gate #(
    .RATE(RATE), .PAY_TIMEOUT(PAY_TIMEOUT),
    .GATE_CYCLES(GATE_CYCLES), .GRACE_TIME(GRACE_TIME)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          done;
    int unsigned cyc;
    logic [7:0]  loc, tt, fee, newcap;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int          gcnt = 0;
  logic [7:0]  last_fee = 8'd0;
  bit          pv[72];
  logic [7:0]  pa[72];
  bit          spur_en, stray_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // monitor: every completion pulse is matched against the oldest prediction
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) gcnt = 0;
    else begin
      if (bus.gate_open) gcnt++;
      if (bus.exit_done || bus.exit_error) begin
        if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          e = sb.pop_front();
          chk("exit_done",     int'(bus.exit_done),     int'(e.done));
          chk("exit_error",    int'(bus.exit_error),    int'(!e.done));
          chk("pulse_cycle",   int'(cyc),               int'(e.cyc));
          chk("park_location", int'(bus.park_location), int'(e.loc));
          chk("time_total",    int'(bus.time_total),    int'(e.tt));
          chk("fee",           int'(bus.fee),           int'(e.fee));
          chk("err_code",      int'(bus.err_code),      int'(e.err));
          chk("new_capacity",  int'(bus.new_capacity),  int'(e.newcap));
          chk("parked",        int'(bus.parked),        $countones(e.newcap));
          chk("empty",         int'(bus.empty),         8 - $countones(e.newcap));
          chk("gate_cycles",   gcnt,                    e.done ? GATE_CYCLES : 0);
        end
        gcnt = 0;
      end
    end
  end

  // reference: outcome and pulse offset (edges after the exit edge)
  task automatic predict(input logic [2:0] tok, input logic [2:0] pat,
                         input logic [7:0] cap, input logic [7:0] tin,
                         input logic [7:0] tout, output exp_t e, output int off);
    int slot, f, paid;
    logic [7:0] tt;
    slot     = int'(tok ^ pat);
    tt       = tout - tin;
    e.loc    = 8'(1 << slot);
    e.tt     = tt;
    e.newcap = cap;
    e.cyc    = 0;
    f = int'(tt) * RATE;
    if (f > 255) f = 255;
`ifdef EXIT_GRACE_EN
    if (int'(tt) <= GRACE_TIME) f = 0;
`endif
    if (cap[slot] == 1'b0) begin
      e.done = 0; e.err = 2'b01; e.fee = last_fee; off = 2;
    end else begin
      last_fee = 8'(f);
      e.fee    = 8'(f);
      e.err    = 2'b00;
      if (f == 0) begin
        e.done = 1; off = 6;
      end else begin
        paid = 0; e.done = 0; e.err = 2'b10; off = 4 + PAY_TIMEOUT - 1;
        for (int k = 0; k < PAY_TIMEOUT; k++) begin
          if (pv[k]) paid = (paid + int'(pa[k]) > 255) ? 255 : paid + int'(pa[k]);
          if (paid >= f) begin
            e.done = 1; e.err = 2'b00; off = 7 + k;
            break;
          end
        end
      end
      if (e.done) e.newcap = cap & ~e.loc;
    end
  endtask

  // called at a negedge with the DUT idle; returns at a negedge, DUT idle again
  task automatic run_txn(input logic [2:0] tok, input logic [2:0] pat,
                         input logic [7:0] cap, input logic [7:0] tin,
                         input logic [7:0] tout);
    exp_t e;
    int   off;
    predict(tok, pat, cap, tin, tout, e, off);
    bus.exit = 1'b1; bus.token = tok; bus.pattern = pat;
    bus.parking_capacity = cap; bus.time_in = tin; bus.time_out = tout;
    @(posedge clk);
    @(negedge clk);
    bus.exit = 1'b0;
    e.cyc = cyc + off;
    sb.push_back(e);
    for (int t = 1; t <= off + 1; t++) begin
      int k;
      k = t - 4;
      bus.pay_valid  = (k >= 0 && k < 72) ? pv[k] : (stray_en && t == 2);
      bus.pay_amount = (k >= 0 && k < 72) ? pa[k] : 8'd255;
      bus.exit       = spur_en && (t <= off) && ($urandom_range(0, 3) == 0);
      bus.token      = 3'($urandom);
      bus.pattern    = 3'($urandom);
      bus.parking_capacity = 8'($urandom);
      bus.time_in    = 8'($urandom);
      bus.time_out   = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    bus.pay_valid = 1'b0;
    bus.exit      = 1'b0;
    chk("idle_after", int'(bus.busy), 0);
    if (sb.size() != 0) begin
      chk("missing_pulse", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic clr_pay();
    for (int k = 0; k < 72; k++) begin pv[k] = 0; pa[k] = 8'd0; end
    spur_en = 0; stray_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] tok, pat;
    logic [7:0] cap, tin, tout;
    int mode, nb, k;

    rst = 1'b1;
    bus.exit = 0; bus.token = 0; bus.pattern = 0; bus.parking_capacity = 0;
    bus.time_in = 0; bus.time_out = 0; bus.pay_valid = 0; bus.pay_amount = 0;
    clr_pay();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   int'(bus.busy), 0);
    chk("rst_gate",   int'(bus.gate_open), 0);
    chk("rst_loc",    int'(bus.park_location), 0);
    chk("rst_fee",    int'(bus.fee), 0);
    chk("rst_newcap", int'(bus.new_capacity), 0);
    chk("rst_parked", int'(bus.parked), 0);
    chk("rst_empty",  int'(bus.empty), 8);
    chk("rst_err",    int'(bus.err_code), 0);
    rst = 1'b0;
    @(negedge clk);

    // normal exit with a spurious exit pulse mid-payment
    clr_pay(); pv[0] = 1; pa[0] = 8'd20; pv[2] = 1; pa[2] = 8'd10; spur_en = 1;
    run_txn(3'b111, 3'b101, 8'b0000_0100, 8'd10, 8'd25);
    chk("tp_fee", int'(bus.fee), 30);
    chk("tp_newcap", int'(bus.new_capacity), 0);
    chk("tp_empty", int'(bus.empty), 8);

    // empty slot (slot 3)
    clr_pay(); stray_en = 1;
    run_txn(3'b110, 3'b101, 8'b0000_0100, 8'd10, 8'd25);
    chk("tp_empty_err", int'(bus.err_code), 1);
    chk("tp_empty_cap", int'(bus.new_capacity), 8'b0000_0100);

    // payment timeout with an underpayment
    clr_pay(); pv[0] = 1; pa[0] = 8'd10;
    run_txn(3'b111, 3'b101, 8'b0000_0100, 8'd10, 8'd25);
    chk("tp_timeout_err", int'(bus.err_code), 2);
    chk("tp_timeout_cap", int'(bus.new_capacity), 8'b0000_0100);

    // timestamp wrap
    clr_pay(); pv[1] = 1; pa[1] = 8'd20;
    run_txn(3'b111, 3'b101, 8'b0000_0100, 8'd250, 8'd4);
    chk("tp_wrap_tt", int'(bus.time_total), 10);
    chk("tp_wrap_fee", int'(bus.fee), 20);

    // fee saturation, payment saturating too
    clr_pay(); pv[0] = 1; pa[0] = 8'd200; pv[3] = 1; pa[3] = 8'd100;
    run_txn(3'b111, 3'b101, 8'b1000_0100, 8'd0, 8'd200);
    chk("tp_sat_fee", int'(bus.fee), 255);

    // payment completing on the timeout edge
    clr_pay(); pv[PAY_TIMEOUT-1] = 1; pa[PAY_TIMEOUT-1] = 8'd30;
    run_txn(3'b111, 3'b101, 8'b0000_0100, 8'd10, 8'd25);
    chk("tp_tie_err", int'(bus.err_code), 0);

    // grace-length stay (no payment offered)
    clr_pay();
    run_txn(3'b000, 3'b000, 8'b0000_0001, 8'd20, 8'd25);
`ifdef EXIT_GRACE_EN
    chk("tp_grace_fee", int'(bus.fee), 0);
`else
    chk("tp_grace_fee", int'(bus.fee), 10);
`endif

    // reset while the gate is open
    clr_pay();
    bus.exit = 1'b1; bus.token = 3'b111; bus.pattern = 3'b101;
    bus.parking_capacity = 8'hFF; bus.time_in = 8'd7; bus.time_out = 8'd7;
    @(posedge clk);
    @(negedge clk);
    bus.exit = 1'b0;
    repeat (4) @(negedge clk);
    chk("rob_gate_pre",   int'(bus.gate_open), 1);
    chk("rob_newcap_pre", int'(bus.new_capacity), 8'hFB);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rob_gate",   int'(bus.gate_open), 0);
    chk("rob_newcap", int'(bus.new_capacity), 0);
    chk("rob_empty",  int'(bus.empty), 8);
    chk("rob_busy",   int'(bus.busy), 0);
    rst = 1'b0;
    last_fee = 8'd0;
    sb.delete();
    @(negedge clk);

    // randomized exits
    for (int n = 0; n < 40; n++) begin
      clr_pay();
      tok = 3'($urandom); pat = 3'($urandom);
      cap = 8'($urandom);
      if ($urandom_range(0, 4) != 0) cap[tok ^ pat] = 1'b1;
      tin  = 8'($urandom);
      mode = $urandom_range(0, 3);
      tout = (mode == 0) ? tin + 8'($urandom_range(0, 6)) : 8'($urandom);
      nb = $urandom_range(0, 5);
      for (int b = 0; b < nb; b++) begin
        k = $urandom_range(0, (mode == 3) ? 70 : 20);
        pv[k] = 1;
        pa[k] = 8'($urandom_range(0, 120));
      end
      spur_en  = ($urandom_range(0, 1) == 1);
      stray_en = ($urandom_range(0, 1) == 1);
      run_txn(tok, pat, cap, tin, tout);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
